// File: rtl/weight_pkg.sv
// Shared definitions for the weight bank read path: geometry helpers,
// FIFO depth, sequencer states and the per-word flag pair.
package weight_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Markers travelling alongside each weight word
    typedef struct packed {
        logic klast;
        logic last;
    } flag_t;

    // Words held by one bank: (Tn/Y) x (Tm/X) kernels of K*K words each
    function automatic int calc_cap(input int tn, input int tm, input int k,
                                    input int x, input int y);
        return (tn / y) * (tm / x) * k * k;
    endfunction

    // Words per kernel
    function automatic int calc_kk(input int k);
        return k * k;
    endfunction

    // Output FIFO depth: enough to absorb every read still in flight
    function automatic int calc_fdepth(input int rd_lat);
        return rd_lat + 2;
    endfunction

    localparam int FDEPTH = calc_fdepth(2);

endpackage

// File: rtl/weight_rd_fifo.sv
// Small synchronous FIFO for returning bank words plus their markers.
// Push and pop may happen in the same cycle, including when full; a push
// into an empty FIFO becomes visible on the following cycle (no bypass).
module weight_rd_fifo
    import weight_pkg::*;
#(
    parameter int DEPTH = FDEPTH,
    parameter int W     = 34,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // Pointer advance with wrap for depths that are not a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == {CW{1'b0}});
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];

    // Accept a write when there is room or a read frees a slot this cycle
    always_comb begin
        wr_en_s = push & (~full | pop);
        rd_en_s = pop & ~empty;
    end

    // Storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_en_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/weight_bank_reader.sv
// Read-side sequencer for one weight bank. Walks addresses 0..CAP-1, tags
// each read so the returning word lands in the output FIFO exactly when the
// bank presents it, and streams the words with kernel/tile markers.
// Optional: define WEIGHT_BANK_READER_REPEAT_EN to add repeat_num, which
// streams the bank repeat_num+1 times back to back.
module weight_bank_reader
    import weight_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int Tn     = 16,
    parameter int Tm     = 16,
    parameter int K      = 3,
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef WEIGHT_BANK_READER_REPEAT_EN
    input  logic [7:0]    repeat_num,
`endif
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_klast,
    output logic          out_last
);

    localparam int CAP   = calc_cap(Tn, Tm, K, X, Y);
    localparam int KK    = calc_kk(K);
    localparam int DEPTH = calc_fdepth(RD_LAT);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int KW    = (KK > 1) ? $clog2(KK) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(CAP - 1);
    localparam logic [KW-1:0] LAST_K    = KW'(KK - 1);

    generate
        if ((CAP < 1) || (CAP > (2 ** AW)) || (RD_LAT < 1)) begin : g_bad_geometry
            $error("weight_bank_reader: bank capacity must be 1..2**AW and RD_LAT >= 1");
        end
    endgenerate

    state_e        state_r;
    state_e        state_s;
    logic          busy_r;
    logic          done_r;
    logic [AW-1:0] rd_addr_r;
    logic [KW-1:0] kcnt_r;
    logic [7:0]    pass_r;
    logic [7:0]    rep_r;
    logic [7:0]    rep_s;
    logic [7:0]    rep_cur_s;
    logic          all_issued_r;
    logic          issue_s;
    logic          final_s;
    logic          klast_s;
    logic          credit_s;
    logic [CW-1:0] inflight_s;
    logic          tag_v_r [RD_LAT];
    flag_t         tag_f_r [RD_LAT];
    logic [DW+1:0] push_data_s;
    logic [DW+1:0] pop_data_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          pop_s;
    flag_t         head_f_s;

`ifdef WEIGHT_BANK_READER_REPEAT_EN
    assign rep_s = repeat_num;
`else
    assign rep_s = 8'd0;
`endif

    // Credit: reads in flight plus words already buffered must fit the FIFO
    always_comb begin
        inflight_s = {CW{1'b0}};
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + CW'(tag_v_r[i]);
        end
        credit_s = (({1'b0, inflight_s} + {1'b0, fifo_count_s}) < (CW + 1)'(DEPTH))
                   & ~fifo_full_s;
    end

    // Markers for the address being issued this cycle
    always_comb begin
        if (state_r == IDLE) begin
            rep_cur_s = rep_s;
        end else begin
            rep_cur_s = rep_r;
        end
        final_s = (rd_addr_r == LAST_ADDR) & (pass_r == rep_cur_s);
        klast_s = (kcnt_r == LAST_K);
    end

    // Next-state and issue decision; the start cycle already issues address 0
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ISSUE;
                    issue_s = credit_s;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (all_issued_r) begin
                    state_s = DRAIN;
                end else begin
                    issue_s = credit_s;
                    if (credit_s && final_s) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end
            end
            DRAIN: begin
                if (pop_s && head_f_s.last) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, status outputs and address/kernel/pass counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rd_addr_r    <= {AW{1'b0}};
            kcnt_r       <= {KW{1'b0}};
            pass_r       <= 8'd0;
            rep_r        <= 8'd0;
            all_issued_r <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ISSUE) | (state_s == DRAIN);
            done_r  <= (state_s == DONE);
            if ((state_r == IDLE) && start) begin
                rep_r <= rep_s;
            end
            if (state_s == IDLE) begin
                rd_addr_r    <= {AW{1'b0}};
                kcnt_r       <= {KW{1'b0}};
                pass_r       <= 8'd0;
                all_issued_r <= 1'b0;
            end else if (issue_s) begin
                if (rd_addr_r == LAST_ADDR) begin
                    rd_addr_r <= {AW{1'b0}};
                    pass_r    <= pass_r + 8'd1;
                end else begin
                    rd_addr_r <= rd_addr_r + AW'(1'b1);
                end
                if (kcnt_r == LAST_K) begin
                    kcnt_r <= {KW{1'b0}};
                end else begin
                    kcnt_r <= kcnt_r + KW'(1'b1);
                end
                if (final_s) begin
                    all_issued_r <= 1'b1;
                end
            end
        end
    end

    // Tag pipe: follows each read through the bank latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v_r[i] <= 1'b0;
                tag_f_r[i] <= '{klast: 1'b0, last: 1'b0};
            end
        end else begin
            tag_v_r[0] <= issue_s;
            tag_f_r[0] <= '{klast: klast_s, last: final_s};
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v_r[i] <= tag_v_r[i-1];
                tag_f_r[i] <= tag_f_r[i-1];
            end
        end
    end

    assign push_data_s = {tag_f_r[RD_LAT-1], rd_data};
    assign pop_s       = ~fifo_empty_s & out_ready;
    assign head_f_s    = flag_t'(pop_data_s[DW+1:DW]);

    weight_rd_fifo #(
        .DEPTH (DEPTH),
        .W     (DW + 2),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_v_r[RD_LAT-1]),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Stream outputs from the FIFO head, forced to zero while nothing is held
    always_comb begin
        out_valid = ~fifo_empty_s;
        if (!fifo_empty_s) begin
            out_data  = pop_data_s[DW-1:0];
            out_klast = head_f_s.klast;
            out_last  = head_f_s.last;
        end else begin
            out_data  = {DW{1'b0}};
            out_klast = 1'b0;
            out_last  = 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign rd_addr = rd_addr_r;

endmodule

// File: tb/tb_weight_bank_reader.sv
// Bench for weight_bank_reader: default geometry (CAP=144, KK=9) plus a
// CAP=1 instance. Bank models return mem[i]=i with a 2-cycle read latency.
module tb_weight_bank_reader;

    localparam int CAP = 144;

    typedef struct packed {
        logic [31:0] data;
        logic        klast;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_klast, out_last;
    logic [9:0]  addr_q;

    logic        start2;
    logic        busy2, done2;
    logic [9:0]  rd_addr2;
    logic [31:0] rd_data2;
    logic [31:0] out_data2;
    logic        out_valid2, out_klast2, out_last2;
    logic        out_ready2;
    logic [9:0]  addr_q2;
`ifdef WEIGHT_BANK_READER_REPEAT_EN
    logic [7:0]  repeat_num;
    logic [7:0]  repeat_num2;
`endif

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;

    weight_bank_reader u_dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef WEIGHT_BANK_READER_REPEAT_EN
        .repeat_num(repeat_num),
`endif
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_klast(out_klast), .out_last(out_last)
    );

    weight_bank_reader #(.Tn(1), .Tm(1), .K(1), .X(1), .Y(1)) u_small (
        .clk(clk), .rst(rst), .start(start2),
`ifdef WEIGHT_BANK_READER_REPEAT_EN
        .repeat_num(repeat_num2),
`endif
        .busy(busy2), .done(done2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_klast(out_klast2), .out_last(out_last2)
    );

    // Bank models: registered address, registered data
    always @(posedge clk) begin
        addr_q   <= rd_addr;
        rd_data  <= {22'd0, addr_q};
        addr_q2  <= rd_addr2;
        rd_data2 <= {22'd0, addr_q2};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input int reps);
        exp_t e;
        for (int p = 0; p < reps; p++) begin
            for (int i = 0; i < CAP; i++) begin
                e.data  = 32'(i);
                e.klast = ((i % 9) == 8);
                e.last  = (p == reps - 1) && (i == CAP - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Called at posedge+1: one-cycle start pulse
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle, or reports a timeout
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc >= budget) begin
                n_vec++; n_err++;
                $display("FAIL wait_done: no done within %0d cycles", budget);
                break;
            end
        end
    endtask

    // Called at posedge+1: wait until this stream has handshaked `target` words
    task automatic wait_hs(input int h0, input int target, input int budget);
        int c = 0;
        while ((hs_cnt - h0) < target) begin
            @(posedge clk); #1;
            c++;
            if (c >= budget) begin
                n_vec++; n_err++;
                $display("FAIL wait_hs: got %0d expected %0d handshakes", hs_cnt - h0, target);
                break;
            end
        end
    endtask

    // After done: exactly one more done, nothing left expected, back idle
    task automatic finish_stream(input string name, input int d0);
        @(posedge clk); #1;
        chk({name, "_done_cnt"}, 64'(done_cnt), 64'(d0 + 1));
        chk({name, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_idle"}, {62'd0, busy, out_valid}, 64'd0);
    endtask

    // 1-in-3 ready pattern, applied only in mode 1
    initial begin
        int tick = 0;
        forever begin
            @(posedge clk); #2;
            if (rdy_mode == 1) begin
                out_ready = ((tick % 3) == 0);
                tick++;
            end
        end
    end

    // Scoreboard monitor and protocol checks on the main instance
    initial begin
        exp_t e;
        logic prev_stall = 1'b0;
        logic exp_done = 1'b0;
        logic [33:0] prev_head = 34'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                exp_done   = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold", {out_valid, out_data, out_klast, out_last}, {1'b1, prev_head});
                end
                if (done || exp_done) begin
                    chk("done_timing", 64'(done), 64'(exp_done));
                end
                exp_done = 1'b0;
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL extra_word: got %0h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", {out_data, out_klast, out_last}, e);
                        exp_done = e.last;
                    end
                end
                if (done) done_cnt++;
                prev_stall = out_valid && !out_ready;
                prev_head  = {out_data, out_klast, out_last};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, first, h0, h, d0;
        rst = 1'b0; start = 1'b0; out_ready = 1'b1;
        start2 = 1'b0; out_ready2 = 1'b1;
`ifdef WEIGHT_BANK_READER_REPEAT_EN
        repeat_num = 8'd0; repeat_num2 = 8'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_main", {busy, done, rd_addr, out_valid, out_klast, out_last, out_data}, 64'd0);
        chk("reset_small", {busy2, done2, rd_addr2, out_valid2, out_klast2, out_last2, out_data2}, 64'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Full-rate stream: latency, one word per cycle, done timing
        push_stream(1);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        chk("valid_in_start_cycle", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                first = c;
                break;
            end
        end
        chk("first_valid_latency", 64'(first), 64'd3);
        chk("busy_streaming", 64'(busy), 64'd1);
        wait_done(400, cyc);
        chk("done_cycle", 64'(first + cyc), 64'd147);
        finish_stream("full_rate", d0);
        chk("rd_addr_idle", 64'(rd_addr), 64'd0);

        // 1-in-3 backpressure
        push_stream(1);
        d0 = done_cnt;
        rdy_mode = 1;
        pulse_start();
        wait_done(1000, cyc);
        @(posedge clk); #1;
        rdy_mode = 0;
        out_ready = 1'b1;
        chk("bp_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        chk("bp_q_empty", 64'(exp_q.size()), 64'd0);

        // 20-cycle stall: credit exhausts, address freezes, head holds
        push_stream(1);
        d0 = done_cnt;
        h0 = hs_cnt;
        pulse_start();
        wait_hs(h0, 30, 200);
        out_ready = 1'b0;
        h = hs_cnt - h0;
        repeat (10) @(negedge clk);
        chk("stall_rd_addr_10", 64'(rd_addr), 64'(h + 4));
        chk("stall_head_10", {out_valid, out_data}, {1'b1, 32'(h)});
        repeat (10) @(negedge clk);
        chk("stall_rd_addr_20", 64'(rd_addr), 64'(h + 4));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(400, cyc);
        finish_stream("stall", d0);

        // Restart mid-stream ignored; start in the done cycle ignored
        push_stream(1);
        d0 = done_cnt;
        h0 = hs_cnt;
        pulse_start();
        wait_hs(h0, 50, 200);
        pulse_start();
        wait_done(400, cyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("start_in_done_ignored", {62'd0, busy, out_valid}, 64'd0);
        chk("restart_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        chk("restart_q_empty", 64'(exp_q.size()), 64'd0);

        // Start in the cycle right after done begins a new stream
        @(posedge clk); #1;
        push_stream(1);
        d0 = done_cnt;
        pulse_start();
        wait_done(400, cyc);
        @(posedge clk); #1;
        push_stream(1);
        pulse_start();
        wait_done(400, cyc);
        finish_stream("back_to_back", d0 + 1);

        // Asynchronous reset mid-stream, then a clean stream
        push_stream(1);
        h0 = hs_cnt;
        pulse_start();
        wait_hs(h0, 70, 200);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", {busy, done, rd_addr, out_valid, out_klast, out_last, out_data}, 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
        push_stream(1);
        pulse_start();
        wait_done(400, cyc);
        finish_stream("after_reset", d0);

        // CAP=1 instance: single word with both markers
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (out_valid2) begin
                first = c;
                break;
            end
        end
        chk("small_latency", 64'(first), 64'd3);
        chk("small_word", {out_data2, out_klast2, out_last2}, {32'd0, 1'b1, 1'b1});
        @(negedge clk);
        chk("small_done", {62'd0, done2, out_valid2}, 64'd2);

`ifdef WEIGHT_BANK_READER_REPEAT_EN
        // Three passes back to back, one tile-end marker, one done
        @(posedge clk); #1;
        push_stream(3);
        d0 = done_cnt;
        repeat_num = 8'd2;
        pulse_start();
        repeat_num = 8'd0;
        wait_done(1000, cyc);
        finish_stream("repeat", d0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
